// File: rtl/rf_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared definitions for the register-file write arbiter: FSM state encoding,
// register-file geometry and the requester ID encoding used for the
// round-robin history bit.
// -----------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    // Two-state controller: normal arbitration or the zero-fill sweep.
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;

    // Index of the final register visited by the clear sweep.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    // Requester identity, stored as the round-robin history.
    typedef logic req_id_t;
    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

endpackage : rf_write_arbiter_pkg

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Purely combinational two-way round-robin grant.
//   valid_a, valid_b : requests pending
//   last_grant       : requester that won the most recent transfer
//   enable           : grants may be issued this cycle
//   grant_a, grant_b : one-hot (or zero) grant
// A lone requester always wins; on a tie the requester not named by
// last_grant wins.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import rf_write_arbiter_pkg::*;
(
    input  logic    valid_a,
    input  logic    valid_b,
    input  req_id_t last_grant,
    input  logic    enable,
    output logic    grant_a,
    output logic    grant_b
);

    // The two tie-break terms are complementary, so the grants can never
    // both be high.
    assign grant_a = enable & valid_a & (~valid_b | (last_grant == REQ_B));
    assign grant_b = enable & valid_b & (~valid_a | (last_grant == REQ_A));

endmodule : rr_arbiter2

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Arbitrates two write requesters onto the single write port of an 8-entry
// register file and can sweep zeros into all 8 entries on request.
//
// Ports
//   i_clk                    : clock, all state updates on the rising edge
//   i_reset                  : synchronous, active-high reset
//   i_req_valid_a/_b         : requester has a write pending
//   i_req_dest_a/_b   [2:0]  : target register index
//   i_req_data_a/_b   [W-1:0]: write data
//   o_req_ready_a/_b         : combinational accept (transfer = valid & ready)
//   i_clear_start            : start zeroing R0..R7 (ignored while clearing)
//   o_clear_busy             : clear sweep in progress (8 cycles)
//   o_clear_done             : one-cycle pulse alongside the R7 clear write
//   o_rf_destination_select  : register file write address (registered)
//   o_rf_data                : register file write data (registered)
//   o_rf_write_enable        : register file write strobe (registered)
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,

    input  logic             i_req_valid_a,
    input  logic [SEL_W-1:0] i_req_dest_a,
    input  logic [W-1:0]     i_req_data_a,
    output logic             o_req_ready_a,

    input  logic             i_req_valid_b,
    input  logic [SEL_W-1:0] i_req_dest_b,
    input  logic [W-1:0]     i_req_data_b,
    output logic             o_req_ready_b,

    input  logic             i_clear_start,
    output logic             o_clear_busy,
    output logic             o_clear_done,

    output logic [SEL_W-1:0] o_rf_destination_select,
    output logic [W-1:0]     o_rf_data,
    output logic             o_rf_write_enable
);

    state_t           r_state;
    state_t           w_state_next;
    logic [SEL_W-1:0] r_clear_cnt;
    req_id_t          r_last_grant;
    logic             r_clear_done;
    logic             r_rf_we;
    logic [SEL_W-1:0] r_rf_sel;
    logic [W-1:0]     r_rf_data;

    logic             w_arb_en;
    logic             w_clear_last;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_xfer_a;
    logic             w_xfer_b;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_arb_en     = 1'b0;
        w_clear_last = 1'b0;
        unique case (r_state)
            ARB: begin
                if (i_clear_start) begin
                    w_state_next = CLEAR;
                end else begin
                    w_arb_en = 1'b1;
                end
            end
            CLEAR: begin
                // i_clear_start is deliberately not looked at here.
                w_clear_last = (r_clear_cnt == LAST_IDX);
                if (w_clear_last) begin
                    w_state_next = ARB;
                end
            end
            default: begin
                w_state_next = ARB;
            end
        endcase
        // Reset holds the ready outputs low even though it only acts at the edge.
        if (i_reset) begin
            w_arb_en = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Grant logic
    // -------------------------------------------------------------------------
    rr_arbiter2 u_rr_arbiter2 (
        .valid_a    (i_req_valid_a),
        .valid_b    (i_req_valid_b),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .grant_a    (w_grant_a),
        .grant_b    (w_grant_b)
    );

    // Grants already include valid, so ready and transfer coincide.
    assign o_req_ready_a = w_grant_a;
    assign o_req_ready_b = w_grant_b;
    assign w_xfer_a      = i_req_valid_a & w_grant_a;
    assign w_xfer_b      = i_req_valid_b & w_grant_b;

    // -------------------------------------------------------------------------
    // Register-file write port, clear counter and round-robin history
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clear_cnt  <= '0;
            r_last_grant <= REQ_B;   // A wins the first tie
            r_clear_done <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_sel     <= '0;
            r_rf_data    <= '0;
        end else begin
            r_clear_done <= 1'b0;
            if (r_state == CLEAR) begin
                r_rf_we      <= 1'b1;
                r_rf_sel     <= r_clear_cnt;
                r_rf_data    <= '0;
                r_clear_cnt  <= r_clear_cnt + SEL_W'(1);
                r_clear_done <= w_clear_last;
            end else begin
                if (i_clear_start) begin
                    r_clear_cnt <= '0;
                end
                // Address and data hold when idle; only the strobe drops.
                r_rf_we <= w_xfer_a | w_xfer_b;
                if (w_xfer_a) begin
                    r_last_grant <= REQ_A;
                    r_rf_sel     <= i_req_dest_a;
                    r_rf_data    <= i_req_data_a;
                end else if (w_xfer_b) begin
                    r_last_grant <= REQ_B;
                    r_rf_sel     <= i_req_dest_b;
                    r_rf_data    <= i_req_data_b;
                end
            end
        end
    end

    assign o_clear_busy            = (r_state == CLEAR);
    assign o_clear_done            = r_clear_done;
    assign o_rf_write_enable       = r_rf_we;
    assign o_rf_destination_select = r_rf_sel;
    assign o_rf_data               = r_rf_data;

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Self-checking bench for rf_write_arbiter: a vector table for arbitration,
// hand-written sequences for clear, clear re-trigger and reset mid-clear.
// Expected register-file outputs are queued as stimulus is applied and
// popped once the edge that produces them has passed.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         va, vb;
    logic [2:0]   da, db;
    logic [W-1:0] xa, xb;
    logic         ra, rb;
    logic         clear_start, clear_busy, clear_done;
    logic [2:0]   rf_sel;
    logic [W-1:0] rf_data;
    logic         rf_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.W(W)) dut (
        .i_clk                   (clk),
        .i_reset                 (reset),
        .i_req_valid_a           (va),
        .i_req_dest_a            (da),
        .i_req_data_a            (xa),
        .o_req_ready_a           (ra),
        .i_req_valid_b           (vb),
        .i_req_dest_b            (db),
        .i_req_data_b            (xb),
        .o_req_ready_b           (rb),
        .i_clear_start           (clear_start),
        .o_clear_busy            (clear_busy),
        .o_clear_done            (clear_done),
        .o_rf_destination_select (rf_sel),
        .o_rf_data               (rf_data),
        .o_rf_write_enable       (rf_we)
    );

    typedef struct {
        logic         we;
        logic [2:0]   sel;
        logic [W-1:0] data;
        logic         done;
    } rf_exp_t;

    typedef struct {
        logic         va;
        logic [2:0]   da;
        logic [W-1:0] xa;
        logic         vb;
        logic [2:0]   db;
        logic [W-1:0] xb;
        logic         ra;
        logic         rb;
    } vec_t;

    rf_exp_t      exp_q[$];
    vec_t         vecs[10];
    logic [2:0]   hold_sel;
    logic [W-1:0] hold_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_write(input logic [2:0] sel, input logic [W-1:0] data, input logic done);
        exp_q.push_back('{1'b1, sel, data, done});
        hold_sel  = sel;
        hold_data = data;
    endtask

    task automatic push_idle();
        exp_q.push_back('{1'b0, hold_sel, hold_data, 1'b0});
    endtask

    task automatic push_reset();
        exp_q.push_back('{1'b0, 3'd0, {W{1'b0}}, 1'b0});
        hold_sel  = '0;
        hold_data = '0;
    endtask

    task automatic drive(input logic a_v, input logic [2:0] a_d, input logic [W-1:0] a_x,
                         input logic b_v, input logic [2:0] b_d, input logic [W-1:0] b_x,
                         input logic cs);
        va = a_v; da = a_d; xa = a_x;
        vb = b_v; db = b_d; xb = b_x;
        clear_start = cs;
    endtask

    // Called just after a falling edge with inputs already driven: checks the
    // combinational/state outputs of this cycle, then the registered outputs
    // after the next rising edge against the scoreboard.
    task automatic tick(input logic exp_ra, input logic exp_rb, input logic exp_busy);
        rf_exp_t e;
        #1;
        check("ready_a", 32'(ra), 32'(exp_ra));
        check("ready_b", 32'(rb), 32'(exp_rb));
        check("clear_busy", 32'(clear_busy), 32'(exp_busy));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("rf_we", 32'(rf_we), 32'(e.we));
            check("rf_sel", 32'(rf_sel), 32'(e.sel));
            check("rf_data", 32'(rf_data), 32'(e.data));
            check("clear_done", 32'(clear_done), 32'(e.done));
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Arbitration vectors; the history bit starts at B after reset.
        vecs[0] = '{1'b1, 3'd3, 4'h5, 1'b0, 3'd0, 4'h0, 1'b1, 1'b0}; // A alone
        vecs[1] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0}; // idle
        vecs[2] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd6, 4'hA, 1'b0, 1'b1}; // B alone x3
        vecs[3] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd6, 4'hB, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 3'd0, 4'h0, 1'b1, 3'd6, 4'hC, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 3'd1, 4'h3, 1'b1, 3'd2, 4'h4, 1'b1, 1'b0}; // tie x4
        vecs[6] = '{1'b1, 3'd1, 4'h3, 1'b1, 3'd2, 4'h4, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 3'd1, 4'h3, 1'b1, 3'd2, 4'h4, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 3'd1, 4'h3, 1'b1, 3'd2, 4'h4, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0}; // idle

        hold_sel  = '0;
        hold_data = '0;

        // Reset with A requesting: ready must stay low throughout.
        reset = 1'b1;
        drive(1'b1, 3'd3, 4'h5, 1'b0, 3'd0, 4'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        push_reset();
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Table-driven arbitration.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].va, vecs[i].da, vecs[i].xa, vecs[i].vb, vecs[i].db, vecs[i].xb, 1'b0);
            if (vecs[i].ra)      push_write(vecs[i].da, vecs[i].xa, 1'b0);
            else if (vecs[i].rb) push_write(vecs[i].db, vecs[i].xb, 1'b0);
            else                 push_idle();
            tick(vecs[i].ra, vecs[i].rb, 1'b0);
        end

        // Clear with A held pending: A accepted in the Clear_Done cycle.
        drive(1'b1, 3'd4, 4'h9, 1'b0, 3'd0, 4'h0, 1'b1);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 3'd4, 4'h9, 1'b0, 3'd0, 4'h0, 1'b0);
            push_write(3'(c), 4'h0, c == 7);
            tick(1'b0, 1'b0, 1'b1);
        end
        push_write(3'd4, 4'h9, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);

        // Clear re-requested mid-sweep is ignored; history (A) survives it.
        drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b1);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, c == 3);
            push_write(3'(c), 4'h0, c == 7);
            tick(1'b0, 1'b0, 1'b1);
        end
        drive(1'b1, 3'd1, 4'h5, 1'b1, 3'd2, 4'h6, 1'b0);
        push_write(3'd2, 4'h6, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);

        // Reset at clear cycle 5 abandons the sweep; next tie goes to A.
        drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b1);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0);
            push_write(3'(c), 4'h0, 1'b0);
            tick(1'b0, 1'b0, 1'b1);
        end
        reset = 1'b1;
        push_reset();
        tick(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        drive(1'b1, 3'd5, 4'h7, 1'b1, 3'd6, 4'h8, 1'b0);
        push_write(3'd5, 4'h7, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 1'b0);
        push_idle();
        tick(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_write_arbiter
